// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Column classification helpers are shared by the scanner FSM.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    typedef enum logic [1:0] {
        COLS_NONE,
        COLS_SINGLE,
        COLS_MULTI
    } col_class_t;

    localparam int         KEY_W     = 4;
    localparam logic [3:0] ROW_RESET = 4'b1110;
    localparam logic [3:0] COL_IDLE  = 4'b1111;

    function automatic col_class_t col_classify(input logic [3:0] c);
        int lows;
        lows = $countones(~c);
        if (lows == 0)
            return COLS_NONE;
        else if (lows == 1)
            return COLS_SINGLE;
        else
            return COLS_MULTI;
    endfunction

    // Index of the lowest low bit; only meaningful when exactly one bit is low.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        if (!v[0])
            return 2'd0;
        else if (!v[1])
            return 2'd1;
        else if (!v[2])
            return 2'd2;
        else
            return 2'd3;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clkin cycles.
// Shared with the display multiplexer so both scan at the same rate.
module tick_divider #(
    parameter int CLK_DIV = 100000
) (
    input  logic clkin,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Emits {row,col} key codes with a one-cycle valid pulse and a held level.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   SCAN     | rotating the driven row, looking for a single low column
//   DEBOUNCE | row locked, counting ticks with an unchanged column pattern
//   HELD     | press accepted, key_down high, waiting for all columns high
//   RELEASE  | counting ticks with all columns high before unlocking
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int CLK_DIV        = 100000,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic [3:0]       col_n,
    output logic [3:0]       row_n,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_down
);

    localparam int DCNT_W = $clog2(DEBOUNCE_TICKS) + 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_TICKS - 1);

    logic tick;

    tick_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_divider (
        .clkin(clkin),
        .rst  (rst),
        .tick (tick)
    );

    logic [3:0] col_meta;
    logic [3:0] cs;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            col_meta <= COL_IDLE;
            cs       <= COL_IDLE;
        end else begin
            col_meta <= col_n;
            cs       <= col_meta;
        end
    end

    state_t            state, state_nx;
    logic [3:0]        row_nx;
    logic [3:0]        pat, pat_nx;
    logic [KEY_W-1:0]  cap_code, cap_code_nx;
    logic [DCNT_W-1:0] dcnt, dcnt_nx;
    logic [KEY_W-1:0]  key_code_nx;
    logic              key_valid_nx;
    logic              key_down_nx;
    logic [3:0]        row_adv;
    col_class_t        cs_class;

    assign row_adv  = {row_n[2:0], row_n[3]};
    assign cs_class = col_classify(cs);

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            row_n     <= ROW_RESET;
            pat       <= COL_IDLE;
            cap_code  <= '0;
            dcnt      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_nx;
            row_n     <= row_nx;
            pat       <= pat_nx;
            cap_code  <= cap_code_nx;
            dcnt      <= dcnt_nx;
            key_code  <= key_code_nx;
            key_valid <= key_valid_nx;
            key_down  <= key_down_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        row_nx       = row_n;
        pat_nx       = pat;
        cap_code_nx  = cap_code;
        dcnt_nx      = dcnt;
        key_code_nx  = key_code;
        key_valid_nx = 1'b0;
        key_down_nx  = key_down;

        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (cs_class == COLS_SINGLE) begin
                        pat_nx      = cs;
                        cap_code_nx = {low_index(row_n), low_index(cs)};
                        dcnt_nx     = '0;
                        state_nx    = DEBOUNCE;
                    end else begin
                        row_nx = row_adv;
                    end
                end
                DEBOUNCE: begin
                    if (cs == pat) begin
                        if (dcnt == DCNT_LAST) begin
                            key_code_nx  = cap_code;
                            key_valid_nx = 1'b1;
                            key_down_nx  = 1'b1;
                            state_nx     = HELD;
                        end else begin
                            dcnt_nx = dcnt + 1'b1;
                        end
                    end else begin
                        // Bounce, early release or a second key: drop it silently.
                        row_nx   = row_adv;
                        state_nx = SCAN;
                    end
                end
                HELD: begin
                    if (cs_class == COLS_NONE) begin
                        dcnt_nx  = '0;
                        state_nx = RELEASE;
                    end
                end
                RELEASE: begin
                    if (cs_class == COLS_NONE) begin
                        if (dcnt == DCNT_LAST) begin
                            key_down_nx = 1'b0;
                            row_nx      = row_adv;
                            state_nx    = SCAN;
                        end else begin
                            dcnt_nx = dcnt + 1'b1;
                        end
                    end else begin
                        state_nx = HELD;
                    end
                end
                default: state_nx = SCAN;
            endcase
        end
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad and emits debounced key events to the countdown/control logic.
- Drives one row low at a time and reads back the four column lines.
- Per key: debounces press and release, then reports one 4-bit key code with a single-cycle valid strobe plus a held level.
- This is the input-side counterpart to the multiplexed 7-segment display driver, running on the same board clock and the same scan tick rate.

Parameters:
- CLK_DIV, 100000: clkin cycles per scan tick; must be >=2.
- DEBOUNCE_TICKS, 10: consecutive stable ticks needed to accept a press or a release; must be >=1.

Ports:
- clkin  input  1  board clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- col_n  input  4  column lines; active-low, pulled up, asynchronous to clkin.
- row_n  output  4  row drive; exactly one bit low at all times.
- key_code  output  4  {row[1:0], col[1:0]} of the last accepted key.
- key_valid  output  1  one-clkin-cycle pulse when a press is accepted.
- key_down  output  1  high from press acceptance until release acceptance.

Behaviour:
- Interface: one clock (clkin); reset rst is asynchronous and active-high.
- Reset values:
  - row_n = 4'b1110 (row 0 driven).
  - key_code = 0, key_valid = 0, key_down = 0.
  - State SCAN; tick counter and debounce counter = 0; col synchronizer = 4'b1111.
  - Reset asserted mid-operation aborts any debounce immediately; no valid pulse is emitted on the way out.
- Synchronizer:
  - col_n passes through a 2-flop synchronizer; the synchronized value is called cs.
  - All decisions use cs, and only on tick cycles.
- Tick:
  - The divider counts 0..CLK_DIV-1 and wraps.
  - tick is high for the one cycle the counter equals CLK_DIV-1.
  - The FSM acts only on tick; off-tick cycles hold all state, except that key_valid returns to 0.
- Column decode:
  - "none" means cs == 4'b1111.
  - "single" means exactly one bit of cs is low; col index = position of that bit.
  - "multi" means two or more bits are low.
- SCAN, on tick:
  - If the current row shows "single": capture cs into pat, capture row and col indices, set dcnt = 0, go to DEBOUNCE. row_n is unchanged.
  - Otherwise ("none" or "multi"): advance row 0->1->2->3->0 by rotating row_n left (1110->1101->1011->0111->1110). Stay in SCAN.
- DEBOUNCE, on tick:
  - If cs == pat: if dcnt == DEBOUNCE_TICKS-1, register key_code = {row,col}, pulse key_valid for exactly one cycle, set key_down = 1, go to HELD. Otherwise dcnt++.
  - If cs != pat (bounce, release, or a second key): return to SCAN and advance the row. No event is emitted.
- HELD, on tick:
  - If cs is "none": dcnt = 0, go to RELEASE.
  - Otherwise stay; extra keys are ignored and there is no auto-repeat.
- RELEASE, on tick:
  - If cs is "none": if dcnt == DEBOUNCE_TICKS-1, key_down = 0, go to SCAN, advance the row. Otherwise dcnt++.
  - Any column low: go back to HELD. key_down stays 1.
- Latency:
  - Press accepted on the (DEBOUNCE_TICKS+1)th tick on which the key is seen, counting the capture tick.
  - key_valid is asserted on the clkin cycle after that tick edge.
  - Add 2 clkin cycles for synchronizer delay.
- Invariants:
  - key_code holds its value until the next accepted press.
  - row_n never changes outside tick cycles.
  - row_n is never all-ones and never has more than one bit low.
  - dcnt is sized to clog2(DEBOUNCE_TICKS)+1 bits and never wraps.

Decomposition:
- Shared package:
  - State enum {SCAN, DEBOUNCE, HELD, RELEASE}.
  - Key-code width constant (4).
  - Row reset pattern 4'b1110.
- Sub-module tick_divider (CLK_DIV parameter, outputs tick). The same block is reused by the display multiplexer, so both scan at one rate.
- Synchronizer and FSM stay inline.

Test Plan (CLK_DIV=4, DEBOUNCE_TICKS=3 unless noted):
- Reset then idle, col_n=1111 for 40 cycles -> row_n cycles 1110,1101,1011,0111,1110, changing every 4 clkin cycles; key_valid never asserts; key_code=0.
- Hold key row2/col1 (col_n=1101 whenever row_n=1011) -> row_n locks at 1011; exactly one key_valid pulse; key_code=4'h9; key_down=1 until release. After release plus 3 stable ticks: key_down=0 and scanning resumes at row3.
- Press row2/col1 for only 2 ticks, then release -> no key_valid; scan resumes.
- Release glitch: while HELD, col_n=1111 for 1 tick then 1101 again -> key_down stays 1; no second key_valid.
- Two keys on the same row (col_n=1001 on row0) -> treated as "multi"; no event; row advances.
- Assert rst mid-DEBOUNCE (after 1 stable tick) -> outputs return to reset values immediately; no key_valid after deassertion until a fresh full debounce.
